// File: rtl/univ_shift_pkg.sv
// Shared encodings for the universal shift register: per-cycle mode codes and burst FSM states.
// No logic lives here; the package is imported by the controller and the top level.
package univ_shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst engine: latches a clamped shift count and direction on start, then enables one shift per cycle.
// Latency: start at edge k gives shifts at k+1..k+n and a registered done pulse after k+n; inputs ignored while busy.
module usr_burst_ctrl
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             dir,
  output logic             shift_en,
  output logic             shift_left,
  output logic             mode_en,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] count_clamped;

  assign count_clamped = (count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : count;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (count_clamped != '0) begin
            state_d = ST_BURST;
            cnt_d   = count_clamped;
            dir_d   = dir;
          end else begin
            // A zero-length burst still owes its requester a completion pulse.
            done_d = 1'b1;
          end
        end
      end
      ST_BURST: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_RIGHT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign shift_en   = (state_q == ST_BURST);
  assign shift_left = dir_q;
  assign mode_en    = (state_q == ST_IDLE) && !start;
  assign busy       = (state_q == ST_BURST);
  assign done       = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift right / shift left / load per cycle, plus autonomous shift bursts.
// Mode ops visible after the sampling edge; during a burst mode/start are ignored. UNIV_SHIFT_ROTATE_EN adds rot.
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] I,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             dir,
`ifdef UNIV_SHIFT_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] A,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] shr_val, shl_val;
  logic             fill_r, fill_l;
  logic             shift_en, shift_left, mode_en;

  usr_burst_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_burst_ctrl (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .count      (count),
    .dir        (dir),
    .shift_en   (shift_en),
    .shift_left (shift_left),
    .mode_en    (mode_en),
    .busy       (busy),
    .done       (done)
  );

`ifdef UNIV_SHIFT_ROTATE_EN
  // Rotation feeds the bit falling off the far end back in, for both mode and burst shifts.
  assign fill_r = rot ? a_q[0]       : sin_r;
  assign fill_l = rot ? a_q[WIDTH-1] : sin_l;
`else
  assign fill_r = sin_r;
  assign fill_l = sin_l;
`endif

  assign shr_val = {fill_r, a_q[WIDTH-1:1]};
  assign shl_val = {a_q[WIDTH-2:0], fill_l};

  always_comb begin
    a_d = a_q;
    if (shift_en) begin
      a_d = shift_left ? shl_val : shr_val;
    end else if (mode_en) begin
      case (mode_e'(mode))
        MODE_SHR:  a_d = shr_val;
        MODE_SHL:  a_d = shl_val;
        MODE_LOAD: a_d = I;
        default:   a_d = a_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '0;
    end else begin
      a_q <= a_d;
    end
  end

  assign A      = a_q;
  assign sout_r = a_q[0];
  assign sout_l = a_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios then random traffic against a cycle-level behavioural model.
// Builds with or without UNIV_SHIFT_ROTATE_EN.
module tb_univ_shift_reg;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic [W-1:0]  I;
  logic          sin_r, sin_l, start, dir, rot;
  logic [CW-1:0] count;
  logic [W-1:0]  A;
  logic          sout_r, sout_l, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: register value, shifts still owed by the active burst, its direction, done pulse.
  int m_a;
  int m_rem;
  int m_dir;
  int m_done;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode),
    .I      (I),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
    .start  (start),
    .count  (count),
    .dir    (dir),
`ifdef UNIV_SHIFT_ROTATE_EN
    .rot    (rot),
`endif
    .A      (A),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .busy   (busy),
    .done   (done)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int shift_val(input int v, input bit left, input bit sr, input bit sl, input bit r);
    int mask = (1 << W) - 1;
    int fill;
    if (left) begin
      fill = r ? ((v >> (W - 1)) & 1) : int'(sl);
      return ((v << 1) & mask) | fill;
    end
    fill = r ? (v & 1) : int'(sr);
    return (v >> 1) | (fill << (W - 1));
  endfunction

  task automatic model_reset();
    m_a = 0; m_rem = 0; m_dir = 0; m_done = 0;
  endtask

  task automatic model_edge();
    bit r;
    int n;
`ifdef UNIV_SHIFT_ROTATE_EN
    r = rot;
`else
    r = 1'b0;
`endif
    m_done = 0;
    if (m_rem > 0) begin
      m_a = shift_val(m_a, m_dir[0], sin_r, sin_l, r);
      m_rem--;
      if (m_rem == 0) m_done = 1;
    end else if (start) begin
      n = (int'(count) > W) ? W : int'(count);
      if (n == 0) m_done = 1;
      else begin
        m_rem = n;
        m_dir = int'(dir);
      end
    end else begin
      case (mode)
        2'b01:   m_a = shift_val(m_a, 1'b0, sin_r, sin_l, r);
        2'b10:   m_a = shift_val(m_a, 1'b1, sin_r, sin_l, r);
        2'b11:   m_a = int'(I);
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    check("A", int'(A), m_a);
    check("busy", int'(busy), (m_rem > 0) ? 1 : 0);
    check("done", int'(done), m_done);
    check("sout_r", int'(sout_r), m_a & 1);
    check("sout_l", int'(sout_l), (m_a >> (W - 1)) & 1);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic mid_reset();
    #2 rst = 1'b0;
    #1 model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load(input logic [W-1:0] v);
    start = 1'b0; mode = 2'b11; I = v;
    cyc();
    mode = 2'b00;
  endtask

  initial begin
    rst = 1'b0; mode = 2'b00; I = '0; sin_r = 1'b0; sin_l = 1'b0;
    start = 1'b0; count = '0; dir = 1'b0; rot = 1'b0;
    model_reset();
    #2;
    compare_all();
    check("rst_A", int'(A), 0);
    @(negedge clk);
    rst = 1'b1;

    // Load and hold
    mode = 2'b11; I = 4'b0110;
    cyc();
    check("load", int'(A), 4'b0110);
    mode = 2'b00;
    repeat (3) cyc();
    check("hold", int'(A), 4'b0110);

    // Mode shifts
    load(4'b1010);
    mode = 2'b01; sin_r = 1'b1;
    cyc();
    check("shr", int'(A), 4'b1101);
    mode = 2'b10; sin_l = 1'b0;
    cyc();
    check("shl", int'(A), 4'b1010);
    mode = 2'b00;

    // Burst right of 3, with a load request ignored mid-burst
    load(4'b1000);
    start = 1'b1; count = CW'(3); dir = 1'b0; sin_r = 1'b0;
    cyc();
    check("burst_busy", int'(busy), 1);
    start = 1'b0; mode = 2'b11; I = 4'b1111;
    repeat (3) cyc();
    mode = 2'b00;
    check("burst_r_A", int'(A), 4'b0001);
    check("burst_r_done", int'(done), 1);
    check("burst_r_busy", int'(busy), 0);
    cyc();
    check("done_once", int'(done), 0);

    // Zero-length burst
    start = 1'b1; count = '0;
    cyc();
    check("cnt0_done", int'(done), 1);
    check("cnt0_busy", int'(busy), 0);
    check("cnt0_A", int'(A), 4'b0001);
    start = 1'b0;
    cyc();

    // Count above WIDTH clamps
    load(4'b1011);
    start = 1'b1; count = CW'(7); dir = 1'b1; sin_l = 1'b0;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    check("clamp_busy", int'(busy), 1);
    cyc();
    check("clamp_A", int'(A), 0);
    check("clamp_done", int'(done), 1);
    cyc();

    // Reset after the second shift of a 4-shift burst
    load(4'b1111);
    start = 1'b1; count = CW'(4); dir = 1'b0; sin_r = 1'b1;
    cyc();
    start = 1'b0;
    repeat (2) cyc();
    mid_reset();
    check("abort_A", int'(A), 0);
    check("abort_busy", int'(busy), 0);
    cyc();
    check("abort_no_done", int'(done), 0);
    start = 1'b1; count = CW'(2); dir = 1'b0; sin_r = 1'b1;
    cyc();
    start = 1'b0;
    repeat (2) cyc();
    check("after_abort_A", int'(A), 4'b1100);
    check("after_abort_done", int'(done), 1);

    // Single left shift with rotate requested
    load(4'b1001);
    rot = 1'b1; start = 1'b1; count = CW'(1); dir = 1'b1; sin_l = 1'b0;
    cyc();
    start = 1'b0;
    cyc();
`ifdef UNIV_SHIFT_ROTATE_EN
    check("rot_A", int'(A), 4'b0011);
`else
    check("norot_A", int'(A), 4'b0010);
`endif
    rot = 1'b0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      mode  = 2'($urandom_range(0, 3));
      I     = W'($urandom);
      sin_r = 1'($urandom);
      sin_l = 1'($urandom);
      start = ($urandom_range(0, 5) == 0);
      count = CW'($urandom_range(0, (1 << CW) - 1));
      dir   = 1'($urandom);
      rot   = 1'($urandom);
      if ($urandom_range(0, 199) == 0) mid_reset();
      else cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register, successor to the 4-bit parallel-load register. It supports per-cycle hold, shift-right, shift-left and parallel-load modes, plus a burst engine that shifts a programmed number of positions autonomously, with busy/done status. It sits in the Registers library as the general-purpose storage and serialisation element for datapath and serial-link blocks.

## Interface
Parameters:
- WIDTH, 4, register width in bits; must be ≥ 2.
- CNT_W, $clog2(WIDTH+1), width of the burst count; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- I  in  WIDTH  parallel load data.
- sin_r  in  1  serial input entering at A[WIDTH-1] on a right shift.
- sin_l  in  1  serial input entering at A[0] on a left shift.
- start  in  1  request a burst; sampled only in IDLE.
- count  in  CNT_W  number of burst shifts.
- dir  in  1  burst direction: 0 right, 1 left.
- rot  in  1  present only with UNIV_SHIFT_ROTATE_EN; see Configuration.
- A  out  WIDTH  register contents.
- sout_r  out  1  A[0], combinational.
- sout_l  out  1  A[WIDTH-1], combinational.
- busy  out  1  high while a burst is in progress.
- done  out  1  one-cycle pulse when a burst completes.

## Operation
Reset (rst=0, asynchronous): A=0, busy=0, done=0, and the FSM enters IDLE. The burst counter is cleared.

FSM states:
- IDLE
  - start=1 and clamped count>0: latch the count and dir, then go to BURST. A is unchanged on this edge.
  - start=1 and count=0: A is unchanged and done=1 for the next cycle. The FSM stays in IDLE.
  - start=0: A is updated per mode.
    - Right shift: A <= {sin_r, A[WIDTH-1:1]}.
    - Left shift: A <= {A[WIDTH-2:0], sin_l}.
    - Load: A <= I.
    - Hold: A unchanged.
- BURST
  - Each edge shifts A one position in the latched dir, using the serial inputs sampled at that edge. The remaining count decrements.
  - On the edge performing the last shift: go to IDLE, busy goes to 0, and done goes to 1 for one cycle.

Rules:
- start has priority over mode in IDLE. When start is sampled, mode is ignored on that edge.
- While in BURST, mode, start, count and dir are ignored. A new start is accepted only in IDLE, including the cycle in which done=1.
- count values greater than WIDTH are clamped to WIDTH.
- done is registered: 1 for exactly one cycle per accepted start.
- If reset is asserted mid-burst, the burst aborts immediately, all outputs return to their reset values, and done is not pulsed.

## Timing
- Mode operations take effect at the edge they are sampled on; A is visible after that edge.
- Burst sequence:
  - start is sampled at edge k.
  - busy=1 from after edge k until edge k+n, where n is the clamped count.
  - Shifts occur at edges k+1 through k+n.
  - done=1 during the cycle after edge k+n.
- Burst throughput: back-to-back bursts cost n+1 cycles each.
- sout_r and sout_l have zero latency relative to A.

## Configuration
- UNIV_SHIFT_ROTATE_EN defined:
  - The input port rot exists.
  - When rot=1, every shift (mode or burst) takes the wrapped bit instead of the serial input.
    - Right: A <= {A[0], A[WIDTH-1:1]}.
    - Left: A <= {A[WIDTH-2:0], A[WIDTH-1]}.
  - In BURST, rot is sampled at each shift edge.
- UNIV_SHIFT_ROTATE_EN undefined: the rot port is absent and shifts always use sin_r/sin_l.

## Structure
- Shared package (univ_shift_pkg):
  - Mode encodings MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD.
  - FSM state encoding ST_IDLE, ST_BURST.
- One sub-module, usr_burst_ctrl, holds the FSM, the count latch/clamp and the decrementer. It outputs the shift-enable, the effective direction, busy and done.
- The top level holds the A register and the next-value mux.

## Test plan
Defaults: WIDTH=4 unless stated.
1. Reset and load:
   - rst=0 → A=0000, busy=0, done=0.
   - Release reset, mode=11, I=0110 → A=0110 after one edge.
   - mode=00 for 3 edges → A stays 0110.
2. Mode shifts:
   - A=1010, mode=01, sin_r=1 → A=1101.
   - Then mode=10, sin_l=0 → A=1010.
   - sout_r and sout_l track A[0] and A[3].
3. Burst right:
   - A=1000, start=1, count=3, dir=0, sin_r=0.
   - Response: busy high for 3 cycles, A=0001, done pulses once.
   - mode=11 applied during the burst is ignored.
4. Burst boundaries:
   - count=0 → done pulses next cycle, A unchanged, busy stays 0.
   - count=7 clamps to 4: A=1011, dir=1, sin_l=0 → A=0000 after 4 shifts.
5. Reset mid-burst:
   - start with count=4, assert rst after the second shift → A=0000, busy=0, no done pulse.
   - After release, a new burst completes normally.
6. UNIV_SHIFT_ROTATE_EN (WIDTH=8):
   - A=10000001, rot=1, burst dir=1, count=1 → A=00000011.
   - Built without the macro, the same stimulus with sin_l=0 → A=00000010.
